// File: rtl/pmesh_mem_responder.sv
// Memory-side responder for the L2 memory channel: services LOAD_MEM/STORE_MEM
// from a small backing store after a fixed programmable latency, one request at a time.
//
// state | meaning
// IDLE  | ready for a request; unknown types are dropped and counted
// WAIT  | latency countdown for the latched request
// RESP  | response held on resp_* until resp_ready
module pmesh_mem_responder #(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = 4,
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_type,
    input  logic [25:0] req_tag,
    input  logic [5:0]  req_source,
    input  logic [63:0] req_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [7:0]  resp_type,
    output logic [25:0] resp_tag,
    output logic [5:0]  resp_source,
    output logic [63:0] resp_data,
    output logic [7:0]  err_count
);

    localparam logic [7:0] LOAD_MEM      = 8'h13;
    localparam logic [7:0] STORE_MEM     = 8'h14;
    localparam logic [7:0] LOAD_MEM_ACK  = 8'h18;
    localparam logic [7:0] STORE_MEM_ACK = 8'h1A;
    localparam logic [7:0] LAT8          = LATENCY[7:0];

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic [7:0]  cnt;
    logic [7:0]  lat_type;
    logic [25:0] lat_tag;
    logic [5:0]  lat_source;
    logic [63:0] lat_data;
    logic [63:0] mem [DEPTH];

    logic        known;
    logic        accept;
    logic        latch;
    logic        enter_resp;
    logic        resp_done;
    logic        err_inc;

    logic [7:0]       e_type;
    logic [25:0]      e_tag;
    logic [5:0]       e_source;
    logic [63:0]      e_data;
    logic [IDX_W-1:0] e_idx;
    logic             e_store;

    assign known      = (req_type == LOAD_MEM) || (req_type == STORE_MEM);
    assign req_ready  = (state == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    always_comb begin
        state_nxt  = state;
        latch      = 1'b0;
        enter_resp = 1'b0;
        resp_done  = 1'b0;
        err_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (known) begin
                        latch = 1'b1;
                        if (LAT8 == 8'd0) begin
                            enter_resp = 1'b1;
                            state_nxt  = RESP;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 8'd1) begin
                    enter_resp = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With zero latency RESP is entered straight from IDLE, so the entry
    // fields come from the request bus rather than the latch.
    always_comb begin
        e_type   = lat_type;
        e_tag    = lat_tag;
        e_source = lat_source;
        e_data   = lat_data;
        if (state == IDLE) begin
            e_type   = req_type;
            e_tag    = req_tag;
            e_source = req_source;
            e_data   = req_data;
        end
    end

    assign e_idx   = e_tag[IDX_W-1:0];
    assign e_store = (e_type == STORE_MEM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 8'd0;
            lat_type   <= 8'd0;
            lat_tag    <= 26'd0;
            lat_source <= 6'd0;
            lat_data   <= 64'd0;
        end else begin
            if (latch) begin
                cnt        <= LAT8;
                lat_type   <= req_type;
                lat_tag    <= req_tag;
                lat_source <= req_source;
                lat_data   <= req_data;
            end else if (state == WAIT) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 64'd0;
            end
        end else if (enter_resp && e_store) begin
            mem[e_idx] <= e_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_type   <= 8'd0;
            resp_tag    <= 26'd0;
            resp_source <= 6'd0;
            resp_data   <= 64'd0;
        end else if (enter_resp) begin
            resp_type   <= e_store ? STORE_MEM_ACK : LOAD_MEM_ACK;
            resp_tag    <= e_tag;
            resp_source <= e_source;
            resp_data   <= e_store ? 64'd0 : mem[e_idx];
        end else if (resp_done) begin
            resp_type   <= 8'd0;
            resp_tag    <= 26'd0;
            resp_source <= 6'd0;
            resp_data   <= 64'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 8'd0;
        end else if (err_inc && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pmesh_mem_responder.sv
// Bench for pmesh_mem_responder: two instances (latency 3 and 0) driven by directed
// and random requests, checked against an array model of the backing store.
module tb_pmesh_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid   [2];
    logic        rq_rdy      [2];
    logic [7:0]  req_type    [2];
    logic [25:0] req_tag     [2];
    logic [5:0]  req_source  [2];
    logic [63:0] req_data    [2];
    logic        resp_valid  [2];
    logic        resp_ready  [2];
    logic [7:0]  resp_type   [2];
    logic [25:0] resp_tag    [2];
    logic [5:0]  resp_source [2];
    logic [63:0] resp_data   [2];
    logic [7:0]  err_count   [2];

    int total = 0;
    int bad   = 0;

    logic [63:0] mdl [2][16];
    int          errm [2];
    int          lat_of [2];

    always #5 clk = ~clk;

    pmesh_mem_responder #(.DEPTH(16), .IDX_W(4), .LATENCY(3)) u0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(rq_rdy[0]), .req_type(req_type[0]),
        .req_tag(req_tag[0]), .req_source(req_source[0]), .req_data(req_data[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_type(resp_type[0]),
        .resp_tag(resp_tag[0]), .resp_source(resp_source[0]), .resp_data(resp_data[0]),
        .err_count(err_count[0])
    );

    pmesh_mem_responder #(.DEPTH(16), .IDX_W(4), .LATENCY(0)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(rq_rdy[1]), .req_type(req_type[1]),
        .req_tag(req_tag[1]), .req_source(req_source[1]), .req_data(req_data[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_type(resp_type[1]),
        .resp_tag(resp_tag[1]), .resp_source(resp_source[1]), .resp_data(resp_data[1]),
        .err_count(err_count[1])
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_outputs_zero(input int d, input logic exp_ready);
        chk("rst_req_ready", 64'(rq_rdy[d]), 64'(exp_ready));
        chk("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
        chk("rst_resp_type", 64'(resp_type[d]), 64'd0);
        chk("rst_resp_tag", 64'(resp_tag[d]), 64'd0);
        chk("rst_resp_source", 64'(resp_source[d]), 64'd0);
        chk("rst_resp_data", resp_data[d], 64'd0);
        chk("rst_err_count", 64'(err_count[d]), 64'd0);
    endtask

    // One known-type transaction; hold = cycles of resp_ready low after resp_valid rises.
    task automatic xact(input int d, input logic [7:0] ty, input logic [25:0] tg,
                        input logic [5:0] src, input logic [63:0] dat, input int hold);
        logic [63:0] exp_data;
        logic [7:0]  exp_type;
        int n;
        @(negedge clk);
        chk("req_ready_idle", 64'(rq_rdy[d]), 64'd1);
        req_valid[d]  = 1'b1;
        req_type[d]   = ty;
        req_tag[d]    = tg;
        req_source[d] = src;
        req_data[d]   = dat;
        resp_ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_data[d]  = {$urandom, $urandom};
        if (ty == 8'h14) begin
            mdl[d][tg[3:0]] = dat;
            exp_type = 8'h1A;
            exp_data = 64'd0;
        end else begin
            exp_type = 8'h18;
            exp_data = mdl[d][tg[3:0]];
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!resp_valid[d]) chk("req_ready_wait", 64'(rq_rdy[d]), 64'd0);
        end while (!resp_valid[d] && n < 64);
        chk("resp_latency", 64'(n), 64'(1 + lat_of[d]));
        chk("resp_type", 64'(resp_type[d]), 64'(exp_type));
        chk("resp_data", resp_data[d], exp_data);
        chk("resp_tag", 64'(resp_tag[d]), 64'(tg));
        chk("resp_source", 64'(resp_source[d]), 64'(src));
        chk("req_ready_resp", 64'(rq_rdy[d]), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid[d]), 64'd1);
            chk("hold_ready", 64'(rq_rdy[d]), 64'd0);
            chk("hold_type", 64'(resp_type[d]), 64'(exp_type));
            chk("hold_data", resp_data[d], exp_data);
            chk("hold_tag", 64'(resp_tag[d]), 64'(tg));
            chk("hold_source", 64'(resp_source[d]), 64'(src));
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        chk("post_valid", 64'(resp_valid[d]), 64'd0);
        chk("post_ready", 64'(rq_rdy[d]), 64'd1);
        chk("post_type", 64'(resp_type[d]), 64'd0);
        chk("post_data", resp_data[d], 64'd0);
    endtask

    task automatic unk(input int d, input logic [7:0] ty);
        @(negedge clk);
        chk("unk_ready", 64'(rq_rdy[d]), 64'd1);
        req_valid[d] = 1'b1;
        req_type[d]  = ty;
        req_tag[d]   = 26'($urandom);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        if (errm[d] < 255) errm[d]++;
        chk("unk_err_count", 64'(err_count[d]), 64'(errm[d]));
        chk("unk_no_resp", 64'(resp_valid[d]), 64'd0);
        chk("unk_ready_next", 64'(rq_rdy[d]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  ty;
        logic [25:0] tg;
        lat_of[0] = 3;
        lat_of[1] = 0;
        for (int d = 0; d < 2; d++) begin
            errm[d] = 0;
            for (int i = 0; i < 16; i++) mdl[d][i] = 64'd0;
            req_valid[d]  = 1'b0;
            req_type[d]   = 8'h00;
            req_tag[d]    = 26'd0;
            req_source[d] = 6'd0;
            req_data[d]   = 64'd0;
            resp_ready[d] = 1'b1;
        end
        rst = 1'b0;

        // reset asserted mid-cycle, then released
        #3 rst = 1'b1;
        #1;
        chk_outputs_zero(0, 1'b0);
        chk_outputs_zero(1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs_zero(0, 1'b1);
        chk_outputs_zero(1, 1'b1);
        xact(0, 8'h13, 26'h0, 6'h01, 64'd0, 0);

        // store then load, latency 3
        xact(0, 8'h14, 26'h5, 6'h03, 64'hDEAD_BEEF_0123_4567, 0);
        xact(0, 8'h13, 26'h5, 6'h2A, 64'd0, 0);

        // back-pressure on a load response
        xact(0, 8'h13, 26'h5, 6'h11, 64'd0, 10);

        // latency 0 and index aliasing
        xact(1, 8'h14, 26'h13, 6'h05, 64'h1, 0);
        xact(1, 8'h13, 26'h3, 6'h06, 64'd0, 0);

        // unknown type dropped three times, then a normal load
        unk(0, 8'h77);
        unk(0, 8'h77);
        unk(0, 8'h77);
        chk("err_count_three", 64'(err_count[0]), 64'd3);
        xact(0, 8'h13, 26'h5, 6'h07, 64'd0, 0);

        // reset two cycles into the wait of a store
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_type[0]   = 8'h14;
        req_tag[0]    = 26'h7;
        req_source[0] = 6'h09;
        req_data[0]   = 64'hFF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_outputs_zero(0, 1'b0);
        chk_outputs_zero(1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            errm[d] = 0;
            for (int i = 0; i < 16; i++) mdl[d][i] = 64'd0;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", 64'(resp_valid[0]), 64'd0);
        end
        xact(0, 8'h13, 26'h7, 6'h0A, 64'd0, 0);
        xact(1, 8'h13, 26'h3, 6'h0B, 64'd0, 0);

        // randomized mix against the model
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 30; k++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0) begin
                    ty = 8'($urandom);
                    if (ty == 8'h13 || ty == 8'h14) ty = 8'h00;
                    unk(d, ty);
                end else begin
                    tg = {22'($urandom), 4'($urandom_range(0, 3))};
                    xact(d, (r < 5) ? 8'h14 : 8'h13, tg, 6'($urandom),
                         {$urandom, $urandom}, int'($urandom_range(0, 2)));
                end
            end
        end

        // err_count saturation
        for (int k = 0; k < 260; k++) unk(1, 8'h55);
        chk("err_count_saturated", 64'(err_count[1]), 64'd255);
        xact(1, 8'h13, 26'h2, 6'h0C, 64'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
